// File: rtl/trigger_arbiter_if.sv
// Trigger request/response bundle between the trigger sources and the arbiter.
// The master side drives requests, configuration and acknowledge. The slave side is the arbiter.
interface trigger_arbiter_if #(
  parameter int NSRC  = 4,
  parameter int WIN_W = 4
);
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]  trig_req;
  logic [NSRC-1:0]  trig_mask;
  logic [WIN_W-1:0] coinc_win;
  logic [15:0]      holdoff;
  logic             buf_ready;
  logic             trig_ack;
  logic             trig_out;
  logic [NSRC-1:0]  trig_type;
  logic [SRC_W-1:0] trig_src;
  logic             busy;
  logic [15:0]      trig_cnt;
  logic [15:0]      lost_cnt;
  logic             ack_err;

  modport master (
    output trig_req, trig_mask, coinc_win, holdoff, buf_ready, trig_ack,
    input  trig_out, trig_type, trig_src, busy, trig_cnt, lost_cnt, ack_err
  );

  modport slave (
    input  trig_req, trig_mask, coinc_win, holdoff, buf_ready, trig_ack,
    output trig_out, trig_type, trig_src, busy, trig_cnt, lost_cnt, ack_err
  );
endinterface

// File: rtl/trigger_arbiter.sv
// Priority trigger arbiter: collects coincident requests over a window, issues one
// trigger, waits for the buffer manager's ACK (with timeout), then applies a dead time.
module trigger_arbiter #(
  parameter int NSRC    = 4,
  parameter int WIN_W   = 4,
  parameter int ACK_TMO = 255
) (
  input logic              clk120_i,
  input logic              resetn_i,
  trigger_arbiter_if.slave trig_bus
);
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, DEAD} state_t;

  state_t           state_q;
  logic [WIN_W-1:0] win_q;
  logic [15:0]      dead_q;
  logic [TMO_W-1:0] tmo_q;
  logic             trig_out_q;
  logic             busy_q;
  logic [NSRC-1:0]  type_q;
  logic [SRC_W-1:0] src_q;
  logic [15:0]      trig_cnt_q;
  logic [15:0]      lost_cnt_q;
  logic             ack_err_q;

  logic [NSRC-1:0]  masked_req;
  logic             valid_req;
  logic [NSRC-1:0]  merged_type;
  logic [15:0]      lost_cnt_inc;
  logic [15:0]      trig_cnt_inc;

  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [SRC_W-1:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = SRC_W'(i);
    end
    return r;
  endfunction

  assign masked_req   = trig_bus.trig_req & trig_bus.trig_mask;
  assign valid_req    = |masked_req;
  assign merged_type  = type_q | masked_req;
  assign lost_cnt_inc = (lost_cnt_q == 16'hFFFF) ? lost_cnt_q : lost_cnt_q + 16'd1;
  assign trig_cnt_inc = (trig_cnt_q == 16'hFFFF) ? trig_cnt_q : trig_cnt_q + 16'd1;

  always_ff @(posedge clk120_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      win_q      <= '0;
      dead_q     <= '0;
      tmo_q      <= '0;
      trig_out_q <= 1'b0;
      busy_q     <= 1'b0;
      type_q     <= '0;
      src_q      <= '0;
      trig_cnt_q <= '0;
      lost_cnt_q <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_req) begin
            if (trig_bus.buf_ready) begin
              type_q  <= masked_req;
              win_q   <= trig_bus.coinc_win;
              busy_q  <= 1'b1;
              state_q <= COLLECT;
            end else begin
              lost_cnt_q <= lost_cnt_inc;
            end
          end
        end
        COLLECT: begin
          type_q <= merged_type;
          if (win_q == '0) begin
            src_q      <= lowest_idx(merged_type);
            trig_out_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= ISSUE;
          end else begin
            win_q <= win_q - WIN_W'(1);
          end
        end
        ISSUE: begin
          if (valid_req) lost_cnt_q <= lost_cnt_inc;
          // ACK on the final allowed cycle still counts as a good handshake.
          if (trig_bus.trig_ack) begin
            trig_cnt_q <= trig_cnt_inc;
            trig_out_q <= 1'b0;
            dead_q     <= trig_bus.holdoff;
            state_q    <= DEAD;
          end else if (tmo_q == TMO_LAST) begin
            ack_err_q  <= 1'b1;
            trig_out_q <= 1'b0;
            dead_q     <= trig_bus.holdoff;
            state_q    <= DEAD;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        DEAD: begin
          if (valid_req) lost_cnt_q <= lost_cnt_inc;
          if (dead_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            dead_q <= dead_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig_bus.trig_out  = trig_out_q;
  assign trig_bus.trig_type = type_q;
  assign trig_bus.trig_src  = src_q;
  assign trig_bus.busy      = busy_q;
  assign trig_bus.trig_cnt  = trig_cnt_q;
  assign trig_bus.lost_cnt  = lost_cnt_q;
  assign trig_bus.ack_err   = ack_err_q;
endmodule
